// File: rtl/refill_arb_pkg.sv
// Shared types and constants for the line-refill arbiter.
// The optional performance counters of refill_arbiter are enabled by
// defining REFILL_ARB_PERF_EN.
package refill_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} refill_arb_state_t;

  localparam int LINE_SIZE_DEF = 64;
  localparam int LINE_OFFSET   = $clog2(LINE_SIZE_DEF);

  // Number of byte-offset bits inside a line of the given size.
  function automatic int line_offset(input int line_size);
    return $clog2(line_size);
  endfunction

endpackage

// File: rtl/refill_arbiter_rr_pick.sv
// Combinational round-robin selector: the winner is the first asserted
// request at or after ptr, searching cyclically upward.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   winner_idx
);

  localparam logic [PTR_W:0] NUM_L = (PTR_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [PTR_W:0]       off;
  logic [PTR_W:0]       sum;
  logic                 found;

  // Rotate so that bit 0 of req_rot is the requester at ptr.
  assign req_dbl = {req, req};
  assign req_rot = NUM_REQ'(req_dbl >> ptr);

  // Distance from ptr to the first pending requester.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_rot[j]) begin
        found = 1'b1;
        off   = (PTR_W+1)'(j);
      end
    end
  end

  // Map the distance back to an absolute index and one-hot vector.
  always_comb begin
    sum = {1'b0, ptr} + off;
    if (sum >= NUM_L) sum = sum - NUM_L;
    winner_idx = sum[PTR_W-1:0];
    winner     = found ? (NUM_REQ'(1) << winner_idx) : '0;
  end

endmodule

// File: rtl/refill_arbiter.sv
// Round-robin arbiter sharing one line-refill read channel between cache
// requesters. One fill in flight at a time: grant, issue to memory, wait
// for the line, return it to the owner.
// Define REFILL_ARB_PERF_EN to add per-requester grant and wait counters.
module refill_arbiter
  import refill_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = LINE_SIZE_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            resp_valid_o,
  output logic [LINE_SIZE*8-1:0]        resp_data_o,
  output logic                          mem_req_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  input  logic                          mem_ready_i,
  input  logic                          mem_valid_i,
  input  logic [LINE_SIZE*8-1:0]        mem_data_i
`ifdef REFILL_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]         perf_grant_cnt_o,
  output logic [NUM_REQ*32-1:0]         perf_wait_cnt_o
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OFF   = line_offset(LINE_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF;

  refill_arb_state_t   state_reg;
  logic [PTR_W-1:0]    rr_ptr_reg;
  logic [NUM_REQ-1:0]  owner_reg;

  logic [NUM_REQ-1:0]  winner;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    next_ptr;
  logic [ADDR_WIDTH-1:0] sel_addr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req        (req_i),
    .ptr        (rr_ptr_reg),
    .winner     (winner),
    .winner_idx (win_idx)
  );

  // Pointer moves just past the winner, wrapping at NUM_REQ-1.
  assign next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // Address of the current winner (one-hot select).
  always_comb begin
    sel_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner[k]) sel_addr = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Fill sequencer; every output is registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= ARB_IDLE;
      rr_ptr_reg   <= '0;
      owner_reg    <= '0;
      gnt_o        <= '0;
      resp_valid_o <= '0;
      resp_data_o  <= '0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
    end else begin
      gnt_o        <= '0;
      resp_valid_o <= '0;
      case (state_reg)
        ARB_IDLE: begin
          if (|req_i) begin
            gnt_o      <= winner;
            owner_reg  <= winner;
            mem_addr_o <= sel_addr & LINE_MASK;
            mem_req_o  <= 1'b1;
            rr_ptr_reg <= next_ptr;
            state_reg  <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (mem_ready_i) begin
            mem_req_o <= 1'b0;
            state_reg <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem_valid_i) begin
            resp_data_o  <= mem_data_i;
            resp_valid_o <= owner_reg;
            state_reg    <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          state_reg <= ARB_IDLE;
        end
        default: begin
          state_reg <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef REFILL_ARB_PERF_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic [31:0] grant_cnt_reg;
    logic [31:0] wait_cnt_reg;

    // Saturating grant and wait counters for requester gi.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        grant_cnt_reg <= '0;
        wait_cnt_reg  <= '0;
      end else begin
        if (gnt_o[gi] && (grant_cnt_reg != 32'hFFFF_FFFF))
          grant_cnt_reg <= grant_cnt_reg + 32'd1;
        if (req_i[gi] && !gnt_o[gi] && (wait_cnt_reg != 32'hFFFF_FFFF))
          wait_cnt_reg <= wait_cnt_reg + 32'd1;
      end
    end

    assign perf_grant_cnt_o[gi*32 +: 32] = grant_cnt_reg;
    assign perf_wait_cnt_o[gi*32 +: 32]  = wait_cnt_reg;
  end
`endif

endmodule
